// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
//
// Parametrised RS-232 receiver. It supports 5..8 data bits, none/odd/even
// parity, and 1 or 2 stop bits. Each received word is placed in a
// valid/ready holding register together with its parity and framing status.
// A sticky overrun flag records any complete frame that was dropped because
// the holding register was still full.
//
// Parameters
//   CLK_FREQ  : system clock frequency in Hz
//   BAUD      : line rate in bit/s (CLKS_PER_BIT = CLK_FREQ/BAUD)
//   DATA_BITS : data bits per frame, 5..8
//   PARITY    : 0 = none, 1 = odd, 2 = even
//   STOP_BITS : 1 or 2
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   RXD        : serial line, idle high, asynchronous to clk
//   rx_data    : received word, LSB = first data bit on the line
//   rx_valid   : rx_data and the error flags are valid
//   rx_ready   : consumer takes the word when rx_valid && rx_ready
//   parity_err : parity mismatch for the held word
//   frame_err  : a stop bit was sampled low for the held word
//   overrun    : sticky, a complete frame was dropped (holding register full)
//   busy       : receiver is in any state other than IDLE
// ---------------------------------------------------------------------------
module uart_rx_param #(
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RXD,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP,
      BREAK
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [2:0]             bitCnt_q, bitCnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   parPend_q, parPend_d;
   logic                   framePend_q, framePend_d;
   logic [DATA_BITS-1:0]   rxData_q, rxData_d;
   logic                   rxValid_q, rxValid_d;
   logic                   parErr_q, parErr_d;
   logic                   frameErr_q, frameErr_d;
   logic                   overrun_q, overrun_d;
   logic                   sync1_q, rxs_q;
   logic                   handshake;
   logic                   complete;

   // Two-flop synchroniser for RXD. Both flops reset to 1 so that reset is
   // not mistaken for a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
      end else begin
         sync1_q <= RXD;
         rxs_q   <= sync1_q;
      end
   end

   // State and datapath register. Every piece of state advances from the
   // next-state values computed in the combinational block below.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bitCnt_q    <= '0;
         shift_q     <= '0;
         parPend_q   <= 1'b0;
         framePend_q <= 1'b0;
         rxData_q    <= '0;
         rxValid_q   <= 1'b0;
         parErr_q    <= 1'b0;
         frameErr_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bitCnt_q    <= bitCnt_d;
         shift_q     <= shift_d;
         parPend_q   <= parPend_d;
         framePend_q <= framePend_d;
         rxData_q    <= rxData_d;
         rxValid_q   <= rxValid_d;
         parErr_q    <= parErr_d;
         frameErr_q  <= frameErr_d;
         overrun_q   <= overrun_d;
      end
   end

   assign handshake = rxValid_q && rx_ready;

   // Receive FSM and holding-register update.
   // The bit-period counter restarts at every sample point, so timing error
   // never accumulates beyond integer truncation.
   // On the final stop sample the frame is either loaded into the holding
   // register (when it is empty or being emptied in the same cycle) or
   // dropped with the overrun flag set.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bitCnt_d    = bitCnt_q;
      shift_d     = shift_q;
      parPend_d   = parPend_q;
      framePend_d = framePend_q;
      rxData_d    = rxData_q;
      rxValid_d   = rxValid_q;
      parErr_d    = parErr_q;
      frameErr_d  = frameErr_q;
      overrun_d   = overrun_q;
      complete    = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d    = '0;
            bitCnt_d = '0;
            if (!rxs_q) begin
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (rxs_q) begin
                  state_d = IDLE;
               end else begin
                  state_d     = DATA;
                  bitCnt_d    = '0;
                  parPend_d   = 1'b0;
                  framePend_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
               if (bitCnt_q == DATA_LAST) begin
                  bitCnt_d = '0;
                  state_d  = (PARITY != 0) ? PAR : STOP;
               end else begin
                  bitCnt_d = bitCnt_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PAR: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = STOP;
               if (PARITY == 1) begin
                  parPend_d = ~(^{shift_q, rxs_q});
               end else begin
                  parPend_d = ^{shift_q, rxs_q};
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (!rxs_q) begin
                  framePend_d = 1'b1;
               end
               if (bitCnt_q == STOP_LAST) begin
                  complete = 1'b1;
                  bitCnt_d = '0;
                  state_d  = rxs_q ? IDLE : BREAK;
               end else begin
                  bitCnt_d = bitCnt_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rxs_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (complete) begin
         if (!rxValid_q || handshake) begin
            rxData_d   = shift_q;
            parErr_d   = (PARITY != 0) && parPend_q;
            frameErr_d = framePend_q | ~rxs_q;
            rxValid_d  = 1'b1;
            if (handshake) begin
               overrun_d = 1'b0;
            end
         end else begin
            overrun_d = 1'b1;
         end
      end else if (handshake) begin
         rxValid_d  = 1'b0;
         parErr_d   = 1'b0;
         frameErr_d = 1'b0;
         overrun_d  = 1'b0;
      end
   end

   assign rx_data    = rxData_q;
   assign rx_valid   = rxValid_q;
   assign parity_err = parErr_q;
   assign frame_err  = frameErr_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised RS-232 receiver, the next generation of the fixed 8N1 receive path inside RS_232_top. Frame format is configurable: 5–8 data bits, none/odd/even parity, 1 or 2 stop bits. Received data is delivered through a valid/ready output register, with parity, framing and overrun status. Sits between the RXD pad and the top-level byte consumer (loopback/TX path or a FIFO).

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD, 9600, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division; 10416 at defaults).
DATA_BITS, 8, data bits per frame. Legal range 5..8.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
RXD  in  1  serial line, idle high, asynchronous to clk.
rx_data  out  DATA_BITS  received word, LSB = first data bit on the line.
rx_valid  out  1  rx_data and error flags are valid.
rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready.
parity_err  out  1  parity mismatch for the held word. Always 0 when PARITY=0.
frame_err  out  1  a stop bit was sampled low for the held word.
overrun  out  1  sticky: a complete frame was dropped because the holding register was full.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counters=0, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. The synchroniser flops reset to 1.
- RXD passes through a 2-flop synchroniser, reset value 1. All decisions use the synchronised signal rxs.
- FSM states: IDLE, START, DATA, PAR, STOP, BREAK.
- IDLE: on rxs=0, go to START and clear the bit counter.
- START: count CLKS_PER_BIT/2 clocks, then sample.
  - rxs=1: false start. Return to IDLE; no output activity.
  - rxs=0: clear the counter and go to DATA.
- DATA: sample every CLKS_PER_BIT clocks (mid-bit). Shift right into the shift register, LSB first. After DATA_BITS samples, go to PAR if PARITY≠0, else STOP.
- PAR: sample once.
  - Odd parity: error if XOR(data, parity bit) ≠ 1.
  - Even parity: error if XOR(data, parity bit) ≠ 0.
- STOP: sample STOP_BITS times, CLKS_PER_BIT apart. frame_err_next=1 if any stop sample is 0.
- Frame completion happens at the clock edge of the last stop sample.
  - If rx_valid=0, or rx_valid && rx_ready in that same cycle: load rx_data, parity_err and frame_err; rx_valid=1 on the next edge.
  - Otherwise: discard the new frame, set overrun=1, and leave rx_data and flags unchanged.
- After completion: go to BREAK if the last stop sample was 0, else IDLE.
- BREAK: wait until rxs=1, then go to IDLE. A held-low line never produces a second frame.
- rx_valid stays high until the handshake. On the handshake edge with no simultaneous completion: rx_valid=0, overrun=0.
- Error flags are valid only while rx_valid=1. They are cleared together with rx_valid.
- Latency: rx_valid rises 1 clock after the last stop sample. That sample is 2 synchroniser clocks plus the mid-bit offset after the line edge.
- Bit-period counter width is $clog2(CLKS_PER_BIT). The counter restarts from 0 at every sample point, with no accumulated drift beyond integer truncation.
- Reset mid-frame aborts immediately. After release, if RXD is low mid-frame, the first low sample can start a spurious frame. The bench waits one full frame of idle after reset.

Test Plan:
1. Defaults (8N1), rx_ready=1, send 0x53 (line bits 1,1,0,0,1,0,1,0, bit period 104167 ns) -> one-cycle rx_valid, rx_data=0x53, parity_err=0, frame_err=0, overrun=0, busy back to 0 after the stop sample.
2. RXD low for 20 µs (< half bit), then high -> returns to IDLE, no rx_valid, rx_data unchanged.
3. PARITY=2: send 0x53 with parity bit 0 -> rx_data=0x53, parity_err=0. Repeat with parity bit 1 -> parity_err=1. PARITY=1 with parity bit 1 -> parity_err=0.
4. Send 0x53 with stop bit 0, line held low for 2 bit times, then high -> frame_err=1, exactly one rx_valid. A subsequent 0xA5 frame is received cleanly with frame_err=0.
5. rx_ready=0: send 0x53 then 0xA5 -> rx_data stays 0x53, overrun=1. Raise rx_ready for one cycle -> handshake, rx_valid=0, overrun=0.
6. Assert rst during data bit 3 of 0x53 -> all outputs 0 immediately. Release, idle 1 frame, send 0x3C with DATA_BITS=7, STOP_BITS=2 -> rx_data=7'h3C, frame_err=0; a low second stop bit -> frame_err=1.
